// File: rtl/ras_predictor.sv
// Return address stack for the Fetch-stage branch predictor, with checkpoint repair.
// Optional `RAS_TOS_REPAIR_EN: repair also rewrites the checkpointed top entry (RepairTopE/TopF).
module ras_predictor #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned RAS_SIZE = 16,
  parameter int unsigned PTRW     = $clog2(RAS_SIZE)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              StallF,
  input  logic              PushF,
  input  logic              PopF,
  input  logic [XLEN-1:0]   PCLinkF,
  input  logic              RepairE,
  input  logic [PTRW-1:0]   RepairPtrE,
  input  logic [PTRW:0]     RepairCountE,
`ifdef RAS_TOS_REPAIR_EN
  input  logic [XLEN-1:0]   RepairTopE,
  output logic [XLEN-1:0]   TopF,
`endif
  output logic [XLEN-1:0]   RetAddrF,
  output logic              RasValidF,
  output logic [PTRW-1:0]   PtrF,
  output logic [PTRW:0]     CountF
);

  localparam int unsigned     CNTW = PTRW + 1;
  localparam logic [CNTW-1:0] FULL = CNTW'(RAS_SIZE);

  logic [XLEN-1:0] mem_q [RAS_SIZE];
  logic [PTRW-1:0] ptr_q, ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            wr_en;
  logic [PTRW-1:0] wr_idx;
  logic [XLEN-1:0] wr_data;

  // Next-state: repair beats stall, stall beats push/pop.
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    wr_data = PCLinkF;
    if (RepairE) begin
      ptr_d   = RepairPtrE;
      count_d = RepairCountE;
`ifdef RAS_TOS_REPAIR_EN
      wr_en   = 1'b1;
      wr_idx  = RepairPtrE;
      wr_data = RepairTopE;
`endif
    end else if (!StallF) begin
      if (PushF && PopF) begin
        // Coroutine jalr: replace the top in place.
        wr_en = 1'b1;
        if (count_q == '0) count_d = CNTW'(1);
      end else if (PushF) begin
        ptr_d  = ptr_q + PTRW'(1);
        wr_en  = 1'b1;
        wr_idx = ptr_q + PTRW'(1);
        if (count_q != FULL) count_d = count_q + CNTW'(1);
      end else if (PopF && (count_q != '0)) begin
        ptr_d   = ptr_q - PTRW'(1);
        count_d = count_q - CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(RAS_SIZE); i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign RetAddrF  = mem_q[ptr_q];
  assign RasValidF = (count_q != '0);
  assign PtrF      = ptr_q;
  assign CountF    = count_q;
`ifdef RAS_TOS_REPAIR_EN
  assign TopF      = mem_q[ptr_q];
`endif

endmodule

// File: tb/tb_ras_predictor.sv
// Self-checking bench for ras_predictor (RAS_SIZE=4): directed scenarios plus randomized traffic vs a stack model.
module tb_ras_predictor;

  localparam int RAS = 4;
  localparam int PW  = 2;
  localparam int CW  = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          StallF, PushF, PopF, RepairE;
  logic [63:0]   PCLinkF;
  logic [PW-1:0] RepairPtrE;
  logic [CW-1:0] RepairCountE;
  logic [63:0]   RetAddrF;
  logic          RasValidF;
  logic [PW-1:0] PtrF;
  logic [CW-1:0] CountF;
`ifdef RAS_TOS_REPAIR_EN
  logic [63:0]   RepairTopE;
  logic [63:0]   TopF;
`endif

  ras_predictor #(.XLEN(64), .RAS_SIZE(RAS)) dut (
    .clk(clk), .reset_n(reset_n), .StallF(StallF), .PushF(PushF), .PopF(PopF),
    .PCLinkF(PCLinkF), .RepairE(RepairE), .RepairPtrE(RepairPtrE),
    .RepairCountE(RepairCountE),
`ifdef RAS_TOS_REPAIR_EN
    .RepairTopE(RepairTopE), .TopF(TopF),
`endif
    .RetAddrF(RetAddrF), .RasValidF(RasValidF), .PtrF(PtrF), .CountF(CountF)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference stack: circular array, integer pointer and occupancy.
  logic [63:0] m_mem [RAS];
  int          m_ptr;
  int          m_cnt;

  wire [69:0] obs = {RetAddrF, RasValidF, PtrF, CountF};

  function automatic logic [69:0] exp_vec();
    return {m_mem[m_ptr], (m_cnt != 0), PW'(m_ptr), CW'(m_cnt)};
  endfunction

  function automatic void model_reset();
    m_ptr = 0;
    m_cnt = 0;
    for (int i = 0; i < RAS; i++) m_mem[i] = '0;
  endfunction

  // Apply one cycle of inputs, advance the model at the edge, then release inputs.
  task automatic drive(input logic push, input logic pop, input logic stall, input logic rep,
                       input int rptr, input int rcnt, input logic [63:0] link,
                       input logic [63:0] rtop);
    PushF = push; PopF = pop; StallF = stall; RepairE = rep;
    RepairPtrE = PW'(rptr); RepairCountE = CW'(rcnt); PCLinkF = link;
`ifdef RAS_TOS_REPAIR_EN
    RepairTopE = rtop;
`endif
    @(posedge clk);
    if (rep) begin
      m_ptr = rptr;
      m_cnt = rcnt;
`ifdef RAS_TOS_REPAIR_EN
      m_mem[rptr] = rtop;
`endif
    end else if (!stall) begin
      if (push && pop) begin
        m_mem[m_ptr] = link;
        if (m_cnt == 0) m_cnt = 1;
      end else if (push) begin
        m_ptr = (m_ptr + 1) % RAS;
        m_mem[m_ptr] = link;
        if (m_cnt < RAS) m_cnt++;
      end else if (pop && m_cnt > 0) begin
        m_ptr = (m_ptr + RAS - 1) % RAS;
        m_cnt--;
      end
    end
    #1;
    PushF = 0; PopF = 0; StallF = 0; RepairE = 0;
    RepairPtrE = '0; RepairCountE = '0; PCLinkF = '0;
`ifdef RAS_TOS_REPAIR_EN
    RepairTopE = '0;
`endif
  endtask

  task automatic pulse_reset();
    reset_n = 0;
    #2;
    reset_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== 70'd0) begin failures++; $display("FAIL reset_init: got %h want 0", obs); end
    reset_n = 1;
    model_reset();
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, 0, 0, 0, 0, 64'(i * 'h100), 0);
      checks++;
      if (obs !== exp_vec()) begin failures++; $display("FAIL reset_push%0d: got %h want %h", i, obs, exp_vec()); end
    end
    #3;
    reset_n = 0;
    #1;
    model_reset();
    checks++;
    if (obs !== 70'd0) begin failures++; $display("FAIL reset_async: got %h want 0", obs); end
    @(posedge clk); #1;
    reset_n = 1;
    checks++;
    if (obs !== 70'd0) begin failures++; $display("FAIL reset_hold: got %h want 0", obs); end
  endtask

  task automatic test_lifo();
    logic [63:0] v;
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, 0, 0, 0, 0, 64'(i * 'h1000), 0);
      checks++;
      if (RetAddrF !== 64'(i * 'h1000) || CountF !== CW'(i))
        begin failures++; $display("FAIL lifo_push%0d: got %h/%0d want %h/%0d", i, RetAddrF, CountF, i * 'h1000, i); end
    end
    for (int i = 0; i < 3; i++) begin
      v = 64'('h3000 - i * 'h1000);
      checks++;
      if (RetAddrF !== v || CountF !== CW'(3 - i) || RasValidF !== 1'b1)
        begin failures++; $display("FAIL lifo_pop%0d: got %h/%0d/%b want %h/%0d/1", i, RetAddrF, CountF, RasValidF, v, 3 - i); end
      drive(0, 1, 0, 0, 0, 0, 0, 0);
    end
    checks++;
    if (RasValidF !== 1'b0 || CountF !== 3'd0 || obs !== exp_vec())
      begin failures++; $display("FAIL lifo_empty: got %h want %h", obs, exp_vec()); end
  endtask

  task automatic test_overflow();
    int saved;
    logic [63:0] v;
    for (int i = 1; i <= 5; i++) drive(1, 0, 0, 0, 0, 0, 64'(i * 'h10), 0);
    checks++;
    if (CountF !== 3'd4 || RetAddrF !== 64'h50)
      begin failures++; $display("FAIL ovf_sat: got cnt=%0d ret=%h want 4/50", CountF, RetAddrF); end
    for (int i = 0; i < 4; i++) begin
      v = 64'('h50 - i * 'h10);
      checks++;
      if (RetAddrF !== v) begin failures++; $display("FAIL ovf_pop%0d: got %h want %h", i, RetAddrF, v); end
      drive(0, 1, 0, 0, 0, 0, 0, 0);
    end
    checks++;
    if (RasValidF !== 1'b0 || CountF !== 3'd0)
      begin failures++; $display("FAIL ovf_empty: got valid=%b cnt=%0d want 0/0", RasValidF, CountF); end
    saved = m_ptr;
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (PtrF !== PW'(saved) || obs !== exp_vec())
      begin failures++; $display("FAIL ovf_underflow: got ptr=%0d want %0d", PtrF, saved); end
  endtask

  task automatic test_push_pop();
    pulse_reset();
    drive(1, 0, 0, 0, 0, 0, 64'h1000, 0);
    drive(1, 0, 0, 0, 0, 0, 64'h2000, 0);
    drive(1, 1, 0, 0, 0, 0, 64'h4000, 0);
    checks++;
    if (RetAddrF !== 64'h4000 || CountF !== 3'd2 || PtrF !== 2'd2)
      begin failures++; $display("FAIL pp_full: got %h/%0d/%0d want 4000/2/2", RetAddrF, CountF, PtrF); end
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 64'h5000, 0);
    checks++;
    if (CountF !== 3'd1 || RasValidF !== 1'b1 || RetAddrF !== 64'h5000 || PtrF !== 2'd0)
      begin failures++; $display("FAIL pp_empty: got %h/%0d/%b/%0d want 5000/1/1/0", RetAddrF, CountF, RasValidF, PtrF); end
  endtask

  task automatic test_repair();
    logic [63:0] v;
    pulse_reset();
    drive(1, 0, 0, 0, 0, 0, 64'h1000, 0);
    drive(1, 0, 0, 0, 0, 0, 64'h2000, 0);
    drive(1, 0, 0, 0, 0, 0, 64'hBAD, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 2, 2, 0, 64'h2000);
    checks++;
    if (PtrF !== 2'd2 || CountF !== 3'd2 || RetAddrF !== 64'h2000)
      begin failures++; $display("FAIL rep_basic: got %0d/%0d/%h want 2/2/2000", PtrF, CountF, RetAddrF); end
    drive(0, 0, 0, 1, 3, 3, 0, 64'hBAD);
    checks++;
    if (RetAddrF !== 64'hBAD || PtrF !== 2'd3)
      begin failures++; $display("FAIL rep_stale3: got %h/%0d want bad/3", RetAddrF, PtrF); end
    // Wrong-path coroutine overwrite of entry 2, then repair back to it.
    drive(0, 0, 0, 1, 2, 2, 0, 64'h2000);
    drive(1, 1, 0, 0, 0, 0, 64'hDEAD, 0);
    drive(0, 0, 0, 1, 2, 2, 0, 64'h2000);
`ifdef RAS_TOS_REPAIR_EN
    v = 64'h2000;
`else
    v = 64'hDEAD;
`endif
    checks++;
    if (RetAddrF !== v) begin failures++; $display("FAIL rep_top: got %h want %h", RetAddrF, v); end
  endtask

  task automatic test_stall();
    drive(1, 0, 1, 0, 0, 0, 64'h7777, 0);
    checks++;
    if (PtrF !== 2'd2 || CountF !== 3'd2 || obs !== exp_vec())
      begin failures++; $display("FAIL stall_push: got %h want %h", obs, exp_vec()); end
    drive(0, 1, 1, 1, 1, 1, 0, 64'h1000);
    checks++;
    if (PtrF !== 2'd1 || CountF !== 3'd1 || RetAddrF !== 64'h1000)
      begin failures++; $display("FAIL stall_repair: got %0d/%0d/%h want 1/1/1000", PtrF, CountF, RetAddrF); end
    drive(1, 0, 0, 1, 3, 4, 64'h9999, 64'hBAD);
    checks++;
    if (PtrF !== 2'd3 || CountF !== 3'd4 || RetAddrF !== 64'hBAD || obs !== exp_vec())
      begin failures++; $display("FAIL repair_over_push: got %h want %h", obs, exp_vec()); end
  endtask

  task automatic test_random();
    logic rep, stall, push, pop;
    for (int n = 0; n < 400; n++) begin
      rep   = ($urandom_range(0, 11) == 0);
      stall = ($urandom_range(0, 4) == 0);
      push  = $urandom_range(0, 1) == 1;
      pop   = $urandom_range(0, 1) == 1;
      drive(push, pop, stall, rep, int'($urandom_range(0, RAS - 1)), int'($urandom_range(0, RAS)),
            {$urandom, $urandom}, {$urandom, $urandom});
      checks++;
      if (obs !== exp_vec()) begin failures++; $display("FAIL rand%0d: got %h want %h", n, obs, exp_vec()); end
`ifdef RAS_TOS_REPAIR_EN
      checks++;
      if (TopF !== m_mem[m_ptr]) begin failures++; $display("FAIL rand_top%0d: got %h want %h", n, TopF, m_mem[m_ptr]); end
`endif
    end
  endtask

  initial begin
    reset_n = 0;
    StallF = 0; PushF = 0; PopF = 0; RepairE = 0;
    PCLinkF = '0; RepairPtrE = '0; RepairCountE = '0;
`ifdef RAS_TOS_REPAIR_EN
    RepairTopE = '0;
`endif
    model_reset();
    test_reset();
    test_lifo();
    test_overflow();
    test_push_pop();
    test_repair();
    test_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ras_predictor.md
Name: ras_predictor

Overview:
- Return address stack for the Fetch-stage branch predictor.
- Sized from the shared configuration record (RAS_SIZE, XLEN) and instantiated beneath the branch predictor.
- Predicts return targets: pushes the link PC on predicted calls and pops on predicted returns.
- Restores its speculative state from a checkpoint when Execute detects a misprediction.

Parameters:
- XLEN, 64, address width of stored return addresses.
- RAS_SIZE, 16, number of entries; power of two, minimum 2.
- PTRW, $clog2(RAS_SIZE), derived pointer width; not overridden by instantiators.

Ports:
- clk  in  1  core clock
- reset_n  in  1  reset, asynchronous, active-low
- StallF  in  1  Fetch stall; blocks all speculative updates
- PushF  in  1  predicted call in Fetch
- PopF  in  1  predicted return in Fetch
- PCLinkF  in  XLEN  link address (PC+2/PC+4) to push
- RepairE  in  1  misprediction in Execute; restore checkpoint
- RepairPtrE  in  PTRW  checkpointed top pointer
- RepairCountE  in  PTRW+1  checkpointed occupancy
- RetAddrF  out  XLEN  predicted return address (top of stack)
- RasValidF  out  1  stack non-empty; RetAddrF usable
- PtrF  out  PTRW  current top pointer, carried down pipeline as checkpoint
- CountF  out  PTRW+1  current occupancy, carried as checkpoint

Behaviour:
- Reset interface (already decided): one clock; reset is asynchronous and active-low, on reset_n.
- Reset state, while reset_n=0: Ptr=0, Count=0, all entries=0. Outputs: RetAddrF=0, RasValidF=0, PtrF=0, CountF=0.
- Storage: circular array of RAS_SIZE × XLEN registers.
  - Ptr indexes the valid top entry.
  - Ptr arithmetic is modulo RAS_SIZE; it wraps naturally at PTRW bits.
- RetAddrF = entry[Ptr], combinational, zero latency.
- RasValidF = (Count != 0).
- Update priority, highest first: RepairE > StallF > push/pop.
- RepairE=1: Ptr<=RepairPtrE, Count<=RepairCountE.
  - Entry contents are not modified (see optional feature).
  - RepairE is honoured even when StallF=1.
- StallF=1 without RepairE: no state change.
- PushF only:
  - Ptr<=Ptr+1; entry[Ptr+1]<=PCLinkF.
  - Count<=min(Count+1, RAS_SIZE).
  - Overflow overwrites the oldest entry silently.
- PopF only, Count>0: Ptr<=Ptr-1, Count<=Count-1.
- PopF only, Count=0 (underflow): no state change; RasValidF stays 0 so the predictor falls back to the BTB.
- PushF and PopF together (coroutine jalr):
  - entry[Ptr]<=PCLinkF; Ptr unchanged.
  - Count<=max(Count,1).
- Neither asserted: hold.
- All state updates take effect on the next rising clk edge.
- Updated RetAddrF is visible one cycle after the push.
- PtrF/CountF always reflect pre-update registered state; the pipeline captures them alongside the prediction.

Optional Feature:
- Macro: RAS_TOS_REPAIR_EN.
- Defined:
  - Adds input RepairTopE (XLEN) and output TopF (= RetAddrF) for checkpointing.
  - On RepairE: also entry[RepairPtrE]<=RepairTopE.
  - Repairs a top entry corrupted by a wrong-path push.
- Undefined:
  - Neither port exists; repair restores pointer and count only.
  - A wrong-path push followed by repair may leave a stale top value.

Test Plan:
1. Reset: drive reset_n=0 asynchronously mid-cycle after 3 pushes -> immediately RasValidF=0, PtrF=0, CountF=0, RetAddrF=0.
2. LIFO: push 0x1000, 0x2000, 0x3000; then pop once per cycle -> RetAddrF shows 0x3000, 0x2000, 0x1000; CountF 3->0; RasValidF drops after the third pop.
3. Overflow, RAS_SIZE=4: push 0x10..0x50 (step 0x10) -> CountF saturates at 4; pops return 0x50, 0x40, 0x30, 0x20; then RasValidF=0; a further pop leaves PtrF unchanged.
4. Push+pop same cycle: with top=0x2000, Count=2, push+pop 0x4000 -> RetAddrF=0x4000, CountF=2, PtrF unchanged. From empty -> CountF=1, RasValidF=1.
5. Repair: capture PtrF=2/CountF=2, push 0xBAD, pop twice, then RepairE with the capture -> PtrF=2, CountF=2. Entry check: 0xBAD at index 3 remains, but RetAddrF=entry[2]. With RAS_TOS_REPAIR_EN and RepairTopE=0x2000 -> RetAddrF=0x2000.
6. Stall/priority: StallF=1 with PushF -> no change. StallF=1 with RepairE -> repair applied. RepairE with PushF -> push ignored.
